// File: rtl/fp32_pkg.sv
// Shared FP32 field widths, divider FSM state type and field-extract helpers.
package fp32_pkg;

    localparam int unsigned FP_W    = 32;
    localparam int unsigned EXP_W   = 8;
    localparam int unsigned MANT_W  = 23;
    localparam int unsigned BIAS    = 127;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    localparam int unsigned SIG_W   = MANT_W + 1;
    localparam int unsigned Q_W     = SIG_W + 1;
    localparam int unsigned CNT_W   = 5;
    localparam int unsigned E_W     = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIVIDE,
        ST_NORM,
        ST_DONE
    } div_state_e;

    function automatic logic fp_sign(input logic [FP_W-1:0] x);
        return x[FP_W-1];
    endfunction

    function automatic logic [EXP_W-1:0] fp_exp(input logic [FP_W-1:0] x);
        return x[FP_W-2:MANT_W];
    endfunction

    function automatic logic [MANT_W-1:0] fp_mant(input logic [FP_W-1:0] x);
        return x[MANT_W-1:0];
    endfunction

endpackage

// File: rtl/div32_if.sv
// Control/data bundle between the calculator control and the FP32 divider.
interface div32_if;
    import fp32_pkg::*;

    logic              en;
    logic              load;
    logic [FP_W-1:0]   A;
    logic [FP_W-1:0]   B;
    logic [FP_W-1:0]   result;
    logic              busy;
    logic              done;
    logic              div_by_zero;

    modport master (output en, load, A, B,
                    input  result, busy, done, div_by_zero);
    modport slave  (input  en, load, A, B,
                    output result, busy, done, div_by_zero);
endinterface

// File: rtl/div_mant_iter.sv
// Restoring mantissa divider: one quotient bit per step, 25 steps per operation.
module div_mant_iter
    import fp32_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_step_en,
    input  logic [SIG_W-1:0] i_ma,
    input  logic [SIG_W-1:0] i_mb,
    output logic             o_last_c,
    output logic [Q_W-1:0]   o_q
);

    logic [Q_W-1:0]   r_rem;
    logic [Q_W-1:0]   r_q;
    logic [SIG_W-1:0] r_mb;
    logic [CNT_W-1:0] r_cnt;

    logic             w_ge;
    logic [SIG_W-1:0] w_diff;

    // Remainder after a step is always below MB, so it fits in SIG_W bits before the shift.
    assign w_ge     = r_rem >= {1'b0, r_mb};
    assign w_diff   = w_ge ? SIG_W'(r_rem - {1'b0, r_mb}) : r_rem[SIG_W-1:0];
    assign o_last_c = (r_cnt == '0);
    assign o_q      = r_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rem <= '0;
            r_q   <= '0;
            r_mb  <= '0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_rem <= {1'b0, i_ma};
            r_mb  <= i_mb;
            r_q   <= '0;
            r_cnt <= CNT_W'(Q_W - 1);
        end else if (i_step_en) begin
            r_rem <= {w_diff, 1'b0};
            r_q   <= {r_q[Q_W-2:0], w_ge};
            if (r_cnt != '0)
                r_cnt <= r_cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/div32.sv
// Sequential FP32 divider: special-case decode, exponent path, normalisation and handshake FSM.
module div32
    import fp32_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    div32_if.slave  bus
);

    div_state_e              r_state;
    logic                    r_sign;
    logic signed [E_W-1:0]   r_exp;
    logic [FP_W-1:0]         r_result;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_dz;
    logic                    r_dz_pend;

    logic [EXP_W-1:0]        w_ea;
    logic [EXP_W-1:0]        w_eb;
    logic                    w_sign;
    logic                    w_b_zero;
    logic                    w_special;
    logic                    w_accept;
    logic                    w_start;
    logic                    w_step;
    logic                    w_last_c;
    logic [Q_W-1:0]          w_q;
    logic signed [E_W-1:0]   w_e_load;
    logic signed [E_W-1:0]   w_norm_exp;
    logic [MANT_W-1:0]       w_norm_mant;
    logic [FP_W-1:0]         w_special_res;
    logic [FP_W-1:0]         w_norm_res;

    assign w_ea      = fp_exp(bus.A);
    assign w_eb      = fp_exp(bus.B);
    assign w_sign    = fp_sign(bus.A) ^ fp_sign(bus.B);
    assign w_b_zero  = (w_eb == '0);
    assign w_special = w_b_zero || (w_ea == '0) || (w_ea == EXP_MAX) || (w_eb == EXP_MAX);

    // A load arriving while done is still showing is dropped.
    assign w_accept  = bus.en && (r_state == ST_IDLE) && bus.load && !r_done;
    assign w_start   = w_accept && !w_special;
    assign w_step    = bus.en && (r_state == ST_DIVIDE);

    assign w_e_load  = $signed(E_W'(w_ea)) - $signed(E_W'(w_eb)) + $signed(E_W'(BIAS));

    // Divide-by-zero and infinite dividend give infinity; the other specials give zero.
    always_comb begin
        w_special_res = {w_sign, (FP_W-1)'(0)};
        if (w_b_zero || (w_ea == EXP_MAX))
            w_special_res = {w_sign, EXP_MAX, MANT_W'(0)};
    end

    assign w_norm_exp  = w_q[Q_W-1] ? r_exp : r_exp - $signed(E_W'(1));
    assign w_norm_mant = w_q[Q_W-1] ? w_q[Q_W-2:1] : w_q[MANT_W-1:0];

    always_comb begin
        w_norm_res = {r_sign, w_norm_exp[EXP_W-1:0], w_norm_mant};
        if (w_norm_exp >= $signed(E_W'(EXP_MAX)))
            w_norm_res = {r_sign, EXP_MAX, MANT_W'(0)};
        else if (w_norm_exp <= $signed(E_W'(0)))
            w_norm_res = {r_sign, (FP_W-1)'(0)};
    end

    div_mant_iter u_iter (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_start),
        .i_step_en (w_step),
        .i_ma      ({1'b1, fp_mant(bus.A)}),
        .i_mb      ({1'b1, fp_mant(bus.B)}),
        .o_last_c  (w_last_c),
        .o_q       (w_q)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_sign    <= 1'b0;
            r_exp     <= '0;
            r_result  <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_dz      <= 1'b0;
            r_dz_pend <= 1'b0;
        end else if (bus.en) begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_sign    <= w_sign;
                        r_exp     <= w_e_load;
                        r_dz      <= 1'b0;
                        r_dz_pend <= w_b_zero;
                        if (w_special) begin
                            r_result <= w_special_res;
                            r_state  <= ST_DONE;
                        end else begin
                            r_busy   <= 1'b1;
                            r_state  <= ST_DIVIDE;
                        end
                    end
                end
                ST_DIVIDE: begin
                    if (w_last_c)
                        r_state <= ST_NORM;
                end
                ST_NORM: begin
                    r_result <= w_norm_res;
                    r_busy   <= 1'b0;
                    r_state  <= ST_DONE;
                end
                ST_DONE: begin
                    r_done  <= 1'b1;
                    r_dz    <= r_dz_pend;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.result      = r_result;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_dz;

endmodule
